// File: rtl/router_pkg.sv
// Constants shared by the router's routing units, input buffers and output arbiters.
package router_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int NUM_PORTS  = 5;

    localparam int PORT_L  = 0;
    localparam int PORT_R  = 1;
    localparam int PORT_U  = 2;
    localparam int PORT_D  = 3;
    localparam int PORT_PE = 4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } oport_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 5,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   idx,
    output logic               any
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0] cand;

    // Walk NUM_REQ candidates starting at ptr; wrap is an explicit compare so
    // non-power-of-two requester counts never visit unused indices.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any && req[cand]) begin
                any      = 1'b1;
                gnt[cand] = 1'b1;
                idx      = cand;
            end
            cand = (cand == LAST) ? '0 : cand + PTR_W'(1);
        end
    end

endmodule

// File: rtl/output_port_arbiter.sv
// Per-output-port round-robin arbiter feeding a single-entry output register
// with send/ready handshake and bypass-on-drain for 1 flit/cycle throughput.
module output_port_arbiter
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = router_pkg::DATA_WIDTH,
    parameter int NUM_REQ    = router_pkg::NUM_PORTS,
    parameter int RR_INIT    = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            reqIn,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] dataIn,
    output logic [NUM_REQ-1:0]            gntOut,
    output logic                          sendOut,
    output logic [DATA_WIDTH-1:0]         dataOut,
    input  logic                          readyIn,
    output logic                          busyOut
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST     = PTR_W'(NUM_REQ - 1);
    localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(RR_INIT);

    oport_state_e          state_q, state_d;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  send_q, send_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic                  cap;
    logic                  grant;
    logic [NUM_REQ-1:0]    arb_gnt;
    logic [PTR_W-1:0]      arb_idx;
    logic                  arb_any;
    logic [DATA_WIDTH-1:0] win_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req (reqIn),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // A full register that drains this cycle frees its slot for a same-cycle capture.
    assign cap     = (state_q == ST_EMPTY) || (send_q && readyIn);
    assign grant   = cap && arb_any && !reset;
    assign gntOut  = grant ? arb_gnt : '0;
    assign busyOut = ~cap;
    assign sendOut = send_q;
    assign dataOut = data_q;

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                win_data = dataIn[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        send_d   = send_q;
        data_d   = data_q;
        case (state_q)
            ST_EMPTY: begin
                if (grant) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (send_q && readyIn && !grant) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (grant) begin
            data_d   = win_data;
            send_d   = 1'b1;
            rr_ptr_d = (arb_idx == LAST) ? '0 : arb_idx + PTR_W'(1);
        end else if (send_q && readyIn) begin
            send_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_EMPTY;
            rr_ptr_q <= PTR_INIT;
            send_q   <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            send_q   <= send_d;
            data_q   <= data_d;
        end
    end

    a_gnt_onehot: assert property (@(posedge clk) $onehot0(gntOut));
    a_gnt_needs_cap: assert property (@(posedge clk) !cap |-> (gntOut == '0));

endmodule
